// File: rtl/tex_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tex_mem_pkg
// Description : Shared types and constants for the texture-cache memory back
//               end. It holds the line geometry (four 16-bit halfwords per
//               64-bit line) and the SRAM line-port state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package tex_mem_pkg;

    localparam int LINE_HW     = 4;   // halfwords per cache line
    localparam int HW_IDX_W    = 2;   // halfword index width
    localparam int LINE_ADDR_W = 20;  // line address width {index,tag}

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ACC   = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sram_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : sram_phase_timer
// Description : Loadable down counter with a terminal-count flag. The line
//               port uses it to time both the read access phase and the write
//               pulse phase.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_load        - load i_load_val this cycle
//               i_load_val    - value to load (phase length minus one)
//               o_tc          - count has reached zero
// Revision    : 1.0 - initial release
// ============================================================================
module sram_phase_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    // The counter parks at zero, so the flag stays set until the next load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_tc = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/sram_line_port.sv
`default_nettype none
// ============================================================================
// Module      : sram_line_port
// Description : Memory-side back end of the texture cache. It serves 64-bit
//               line fills and write-throughs on an asynchronous 16-bit SRAM
//               as four halfword accesses. Each line is returned as two
//               32-bit beats, with one mem_ready pulse per beat. A single
//               pending slot absorbs one strobe that arrives while a
//               transaction is already in flight.
// Ports       : mem_*    - cache-controller side (strobes, line data, beats)
//               busy     - transaction in flight or pending
//               err_overrun - sticky, set when a strobe is dropped
//               sram_*   - asynchronous SRAM pins (active-low controls)
// Revision    : 1.0 - initial release
// ============================================================================
module sram_line_port
    import tex_mem_pkg::*;
#(
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] mem_addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [63:0] mem_wrdata,
    output logic        mem_ready,
    output logic [31:0] mem_rddata,
    output logic        busy,
    output logic        err_overrun,
    output logic [21:0] sram_addr,
    output logic [15:0] sram_dq_o,
    input  logic [15:0] sram_dq_i,
    output logic        sram_dq_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    localparam int c_MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int c_TMR_W   = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;
    localparam logic [c_TMR_W-1:0]  c_RD_LOAD = c_TMR_W'(RD_CYCLES - 1);
    localparam logic [c_TMR_W-1:0]  c_WR_LOAD = c_TMR_W'(WR_CYCLES - 1);
    localparam logic [HW_IDX_W-1:0] c_HW_LAST = HW_IDX_W'(LINE_HW - 1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [HW_IDX_W-1:0]      r_hw;
    logic [LINE_ADDR_W-1:0]   r_addr;
    logic [63:0]              r_wdata;
    logic                     r_pend_v;
    logic                     r_pend_wr;
    logic [LINE_ADDR_W-1:0]   r_pend_addr;
    logic [63:0]              r_pend_data;
    logic                     r_err;
    logic [15:0]              r_hw_lo;
    logic                     r_ready;
    logic [31:0]              r_rddata;

    logic                     w_launch;
    logic                     w_launch_wr;
    logic                     w_tmr_load;
    logic [c_TMR_W-1:0]       w_tmr_val;
    logic                     w_tc;
    logic                     w_hw_inc;
    logic                     w_rd_sample;
    logic                     w_wr_beat;
    logic                     w_slot_free;
    logic                     w_rd_to_slot;
    logic                     w_wr_to_slot;
    logic                     w_drop;

    sram_phase_timer #(
        .WIDTH (c_TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_tc       (w_tc)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and phase control. Every transaction leaves through IDLE,
    // so at least one ce_n-high cycle always separates two transactions.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_launch_wr = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        w_hw_inc    = 1'b0;
        w_rd_sample = 1'b0;
        w_wr_beat   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A parked transaction takes precedence over new strobes.
                if (r_pend_v) begin
                    w_launch    = 1'b1;
                    w_launch_wr = r_pend_wr;
                end else if (mem_read) begin
                    w_launch    = 1'b1;
                    w_launch_wr = 1'b0;
                end else if (mem_write) begin
                    w_launch    = 1'b1;
                    w_launch_wr = 1'b1;
                end
                if (w_launch) begin
                    if (w_launch_wr) begin
                        w_state_nxt = ST_WR_SETUP;
                    end else begin
                        w_state_nxt = ST_RD_ACC;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = c_RD_LOAD;
                    end
                end
            end
            ST_RD_ACC: begin
                if (w_tc) begin
                    w_rd_sample = 1'b1;
                    if (r_hw == c_HW_LAST) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_hw_inc   = 1'b1;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = c_RD_LOAD;
                    end
                end
            end
            ST_WR_SETUP: begin
                w_state_nxt = ST_WR_PULSE;
                w_tmr_load  = 1'b1;
                w_tmr_val   = c_WR_LOAD;
            end
            ST_WR_PULSE: begin
                if (w_tc) begin
                    w_state_nxt = ST_WR_HOLD;
                end
            end
            ST_WR_HOLD: begin
                // Odd halfwords complete a 32-bit beat.
                w_wr_beat = r_hw[0];
                if (r_hw == c_HW_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_hw_inc    = 1'b1;
                    w_state_nxt = ST_WR_SETUP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pending-slot routing. In IDLE with an empty slot, a lone strobe
    // launches directly and a read+write pair parks the write. Otherwise
    // strobes compete for the slot, read first. The slot counts as free when
    // it is being emptied by a launch this very cycle. A strobe that finds
    // no room is dropped.
    // ------------------------------------------------------------------
    always_comb begin
        w_slot_free  = 1'b0;
        w_rd_to_slot = 1'b0;
        w_wr_to_slot = 1'b0;
        w_drop       = 1'b0;
        if ((r_state == ST_IDLE) && !r_pend_v) begin
            w_wr_to_slot = mem_read && mem_write;
        end else begin
            w_slot_free  = (r_state == ST_IDLE) || !r_pend_v;
            w_rd_to_slot = mem_read && w_slot_free;
            w_wr_to_slot = mem_write && w_slot_free && !mem_read;
            w_drop       = (mem_read && !w_slot_free) ||
                           (mem_write && !(w_slot_free && !mem_read));
        end
    end

    // ------------------------------------------------------------------
    // Datapath: transaction registers, pending slot, beat assembly
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hw        <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_pend_v    <= 1'b0;
            r_pend_wr   <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= '0;
            r_err       <= 1'b0;
            r_hw_lo     <= '0;
            r_ready     <= 1'b0;
            r_rddata    <= '0;
        end else begin
            r_ready <= 1'b0;

            if (w_launch) begin
                r_hw    <= '0;
                r_addr  <= r_pend_v ? r_pend_addr : mem_addr;
                r_wdata <= r_pend_v ? r_pend_data : mem_wrdata;
            end else if (w_hw_inc) begin
                r_hw <= r_hw + 1'b1;
            end

            if (w_rd_to_slot || w_wr_to_slot) begin
                r_pend_v    <= 1'b1;
                r_pend_wr   <= w_wr_to_slot;
                r_pend_addr <= mem_addr;
                r_pend_data <= mem_wrdata;
            end else if (w_launch && r_pend_v) begin
                r_pend_v <= 1'b0;
            end

            if (w_drop) begin
                r_err <= 1'b1;
            end

            // The even halfword is held until its odd partner arrives.
            if (w_rd_sample) begin
                if (!r_hw[0]) begin
                    r_hw_lo <= sram_dq_i;
                end else begin
                    r_rddata <= {sram_dq_i, r_hw_lo};
                    r_ready  <= 1'b1;
                end
            end

            if (w_wr_beat) begin
                r_rddata <= r_hw[1] ? r_wdata[63:32] : r_wdata[31:0];
                r_ready  <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The SRAM controls decode straight from the state register.
    // ------------------------------------------------------------------
    assign sram_ce_n   = (r_state == ST_IDLE);
    assign sram_oe_n   = (r_state != ST_RD_ACC);
    assign sram_we_n   = (r_state != ST_WR_PULSE);
    assign sram_dq_oe  = (r_state == ST_WR_SETUP) || (r_state == ST_WR_PULSE) ||
                         (r_state == ST_WR_HOLD);
    assign sram_addr   = {r_addr, r_hw};
    assign sram_dq_o   = r_wdata[{r_hw, 4'b0000} +: 16];

    // busy also covers the final-beat cycle, when the FSM is already idle.
    assign busy        = (r_state != ST_IDLE) || r_pend_v || r_ready;
    assign mem_ready   = r_ready;
    assign mem_rddata  = r_rddata;
    assign err_overrun = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sram_line_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_line_port
// Description : Self-checking bench for sram_line_port. A line-level reference
//               model predicts each beat (cycle and data) and pushes it to a
//               scoreboard queue. A monitor pops one entry per mem_ready.
//               busy and err_overrun are compared every cycle. A second
//               instance with single-cycle phases checks the short timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_line_port;

    localparam int R = 2;
    localparam int W = 2;

    logic        clk;
    logic        rst;
    logic [19:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_wrdata;
    logic        mem_ready;
    logic [31:0] mem_rddata;
    logic        busy;
    logic        err_overrun;
    logic [21:0] sram_addr;
    logic [15:0] sram_dq_o;
    logic [15:0] sram_dq_i;
    logic        sram_dq_oe;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;

    logic [19:0] f_addr;
    logic        f_read;
    logic        f_write;
    logic [63:0] f_wdata;
    logic        f_ready;
    logic [31:0] f_rddata;
    logic        f_busy;
    logic        f_err;
    logic [21:0] f_saddr;
    logic [15:0] f_dq_o;
    logic [15:0] f_dq_i;
    logic        f_dq_oe;
    logic        f_ce_n;
    logic        f_oe_n;
    logic        f_we_n;

    sram_line_port #(.RD_CYCLES(R), .WR_CYCLES(W)) u_dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_read(mem_read),
        .mem_write(mem_write), .mem_wrdata(mem_wrdata), .mem_ready(mem_ready),
        .mem_rddata(mem_rddata), .busy(busy), .err_overrun(err_overrun),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
        .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n)
    );

    sram_line_port #(.RD_CYCLES(1), .WR_CYCLES(1)) u_dut_fast (
        .clk(clk), .rst(rst), .mem_addr(f_addr), .mem_read(f_read),
        .mem_write(f_write), .mem_wrdata(f_wdata), .mem_ready(f_ready),
        .mem_rddata(f_rddata), .busy(f_busy), .err_overrun(f_err),
        .sram_addr(f_saddr), .sram_dq_o(f_dq_o), .sram_dq_i(f_dq_i),
        .sram_dq_oe(f_dq_oe), .sram_ce_n(f_ce_n), .sram_oe_n(f_oe_n),
        .sram_we_n(f_we_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // SRAM behavioural model (main instance). Unwritten halfwords read back
    // as the low 16 bits of their own address.
    // ------------------------------------------------------------------
    logic [15:0] sram_mem [int];
    int          wlow [int];
    logic [21:0] rd_trace [$];

    function automatic logic [15:0] sram_rd(input int a);
        if (sram_mem.exists(a)) return sram_mem[a];
        return a[15:0];
    endfunction

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            sram_mem[int'(sram_addr)] = sram_dq_o;
            wlow[int'(sram_addr)] = wlow.exists(int'(sram_addr)) ? wlow[int'(sram_addr)] + 1 : 1;
        end
        if (!sram_ce_n && !sram_oe_n) rd_trace.push_back(sram_addr);
    end

    always @(negedge clk)
        sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_rd(int'(sram_addr)) : 16'h0000;

    assign f_dq_i = (!f_ce_n && !f_oe_n) ? f_saddr[15:0] : 16'h0000;

    // ------------------------------------------------------------------
    // Line-level reference model
    // ------------------------------------------------------------------
    typedef struct {
        int          cyc;
        logic [31:0] data;
    } beat_t;

    beat_t       exp_q [$];
    logic [15:0] ref_mem [int];
    int          busy_until = -100;   // last non-idle cycle of the current transaction
    bit          pend_v  = 1'b0;
    bit          pend_wr = 1'b0;
    logic [19:0] pend_addr = '0;
    logic [63:0] pend_data = '0;
    bit          err_exp = 1'b0;

    function automatic logic [15:0] ref_rd(input int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return a[15:0];
    endfunction

    // Transaction launched at the edge that ends cycle c.
    task automatic launch(input bit wr, input logic [19:0] a, input logic [63:0] d, input int c);
        int          p;
        int          base;
        beat_t       b;
        logic [15:0] h [4];
        p    = wr ? (W + 2) : R;
        base = int'(a) * 4;
        if (wr) for (int k = 0; k < 4; k++) ref_mem[base + k] = d[16*k +: 16];
        for (int k = 0; k < 4; k++) h[k] = ref_rd(base + k);
        busy_until = c + 4 * p;
        b.cyc = c + 1 + 2 * p; b.data = {h[1], h[0]}; exp_q.push_back(b);
        b.cyc = c + 1 + 4 * p; b.data = {h[3], h[2]}; exp_q.push_back(b);
    endtask

    task automatic offer(input bit rd, input bit wr, input logic [19:0] a, input logic [63:0] d);
        if (rd) begin
            if (!pend_v) begin pend_v = 1; pend_wr = 0; pend_addr = a; end
            else err_exp = 1;
        end
        if (wr) begin
            if (!pend_v) begin pend_v = 1; pend_wr = 1; pend_addr = a; pend_data = d; end
            else err_exp = 1;
        end
    endtask

    task automatic model_step(input int c, input bit rd, input bit wr,
                              input logic [19:0] a, input logic [63:0] d);
        if (c > busy_until) begin
            if (pend_v) begin
                pend_v = 0;
                launch(pend_wr, pend_addr, pend_data, c);
                offer(rd, wr, a, d);
            end else if (rd) begin
                launch(1'b0, a, d, c);
                if (wr) begin pend_v = 1; pend_wr = 1; pend_addr = a; pend_data = d; end
            end else if (wr) begin
                launch(1'b1, a, d, c);
            end
        end else begin
            offer(rd, wr, a, d);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        busy_until = -100;
        pend_v     = 0;
        err_exp    = 0;
    endtask

    // One clock of stimulus: check this cycle's status, then drive strobes.
    task automatic tick(input bit rd, input bit wr, input logic [19:0] a, input logic [63:0] d);
        @(negedge clk);
        chk("busy", busy, (cyc <= busy_until + 1) || pend_v);
        chk("err_overrun", err_overrun, err_exp);
        mem_read   = rd;
        mem_write  = wr;
        mem_addr   = a;
        mem_wrdata = d;
        model_step(cyc, rd, wr, a, d);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !pend_v && cyc > busy_until + 1) break;
            tick(1'b0, 1'b0, 20'h0, 64'h0);
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    // ------------------------------------------------------------------
    // Scoreboard monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            chk("missed_beat", 0, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (mem_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", mem_rddata, 0);
                checks++;
                errors++;
                $display("FAIL unexpected_ready at cycle %0d: got 1, expected 0", cyc);
            end else begin
                chk("beat_cycle", cyc, exp_q[0].cyc);
                chk("beat_data", mem_rddata, exp_q[0].data);
                void'(exp_q.pop_front());
            end
        end
    end

    // ------------------------------------------------------------------
    // Short-phase instance stimulus and recording
    // ------------------------------------------------------------------
    int          f_cyc [$];
    logic [31:0] f_dat [$];
    int          s_f_rd = 0;
    int          s_f_wr = 0;
    logic [63:0] f_wline = 64'hDEAD_BEEF_CAFE_F00D;

    always @(negedge clk) begin
        if (f_ready === 1'b1) begin
            f_cyc.push_back(cyc);
            f_dat.push_back(f_rddata);
        end
    end

    initial begin
        f_read = 0; f_write = 0; f_addr = '0; f_wdata = '0;
        @(negedge rst);
        repeat (2) @(negedge clk);
        s_f_rd = cyc; f_addr = 20'h00100; f_read = 1;
        @(negedge clk);
        f_read = 0;
        repeat (9) @(negedge clk);
        s_f_wr = cyc; f_wdata = f_wline; f_write = 1;
        @(negedge clk);
        f_write = 0;
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    logic [21:0] t1_base;
    logic [63:0] t2_line;
    logic [21:0] f_base;

    initial begin
        rst = 1; mem_read = 0; mem_write = 0; mem_addr = '0; mem_wrdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_ready", mem_ready, 0);
        chk("rst_mem_rddata", mem_rddata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_overrun, 0);
        chk("rst_ce_n", sram_ce_n, 1);
        chk("rst_oe_n", sram_oe_n, 1);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_dq_oe", sram_dq_oe, 0);
        chk("rst_addr", sram_addr, 0);
        rst = 0;

        // Line fill; each halfword address is held for R cycles, in order.
        rd_trace.delete();
        t1_base = {20'h12345, 2'b00};
        tick(1'b1, 1'b0, 20'h12345, 64'h0);
        drain();
        chk("t1_trace_len", rd_trace.size(), 4 * R);
        for (int i = 0; i < 4 * R; i++)
            if (i < rd_trace.size()) chk("t1_trace_addr", rd_trace[i], t1_base + 22'(i / R));

        // Line write; exactly W we_n-low cycles per halfword.
        t2_line = 64'h4444_3333_2222_1111;
        tick(1'b0, 1'b1, 20'h00001, t2_line);
        drain();
        for (int k = 0; k < 4; k++) begin
            chk("t2_sram_hw", sram_rd(4 + k), t2_line[16*k +: 16]);
            chk("t2_we_cycles", wlow.exists(4 + k) ? wlow[4 + k] : 0, W);
        end

        // Simultaneous read and write to the same line.
        tick(1'b1, 1'b1, 20'h00010, {$urandom, $urandom});
        drain();

        // Third strobe while slot full and a read is in flight.
        tick(1'b1, 1'b0, 20'h00011, 64'h0);
        tick(1'b0, 1'b0, 20'h0, 64'h0);
        tick(1'b0, 1'b1, 20'h00012, {$urandom, $urandom});
        tick(1'b0, 1'b0, 20'h0, 64'h0);
        tick(1'b1, 1'b0, 20'h00013, 64'h0);
        drain();

        // Reset in cycle 6 of a write; line 1 is left torn and not read again.
        tick(1'b0, 1'b1, 20'h00001, 64'h0F0E_0D0C_0B0A_0908);
        repeat (5) tick(1'b0, 1'b0, 20'h0, 64'h0);
        @(negedge clk);
        mem_read = 0; mem_write = 0;
        rst = 1;
        model_reset();
        @(negedge clk);
        chk("t5_ce_n", sram_ce_n, 1);
        chk("t5_we_n", sram_we_n, 1);
        chk("t5_dq_oe", sram_dq_oe, 0);
        chk("t5_busy", busy, 0);
        chk("t5_ready", mem_ready, 0);
        rst = 0;
        tick(1'b1, 1'b0, 20'h00014, 64'h0);
        drain();

        // Randomized traffic over a small set of lines.
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 99);
            tick((r < 9) || (r == 99), ((r >= 9) && (r < 16)) || (r == 99),
                 20'h00010 + 20'($urandom_range(0, 7)), {$urandom, $urandom});
        end
        tick(1'b0, 1'b0, 20'h0, 64'h0);
        drain();

        // Short-phase instance: R=W=1.
        f_base = {20'h00100, 2'b00};
        chk("fast_beat_count", f_cyc.size(), 4);
        if (f_cyc.size() == 4) begin
            chk("fast_rd_b0_cycle", f_cyc[0], s_f_rd + 3);
            chk("fast_rd_b1_cycle", f_cyc[1], s_f_rd + 5);
            chk("fast_wr_b0_cycle", f_cyc[2], s_f_wr + 7);
            chk("fast_wr_b1_cycle", f_cyc[3], s_f_wr + 13);
            chk("fast_rd_b0_data", f_dat[0], {16'(f_base + 22'd1), 16'(f_base)});
            chk("fast_rd_b1_data", f_dat[1], {16'(f_base + 22'd3), 16'(f_base + 22'd2)});
            chk("fast_wr_b0_data", f_dat[2], f_wline[31:0]);
            chk("fast_wr_b1_data", f_dat[3], f_wline[63:32]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
